// File: rtl/rc4_pkg.sv
// Shared state encodings and constants for the RC4 stream engine.
package rc4_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE  = 4'd0;
  localparam state_t ST_INIT  = 4'd1;
  localparam state_t ST_K_RDI = 4'd2;
  localparam state_t ST_K_RDJ = 4'd3;
  localparam state_t ST_K_WRI = 4'd4;
  localparam state_t ST_K_WRJ = 4'd5;
  localparam state_t ST_P_IN  = 4'd6;
  localparam state_t ST_P_RDJ = 4'd7;
  localparam state_t ST_P_WRI = 4'd8;
  localparam state_t ST_P_WRJ = 4'd9;
  localparam state_t ST_P_RDK = 4'd10;
  localparam state_t ST_P_OUT = 4'd11;
  localparam state_t ST_D_INC = 4'd12;

  // S-box RAM returns read data one cycle after the address
  localparam int unsigned RAM_RD_LATENCY = 1;

endpackage

// File: rtl/rc4_stream_engine_key_sel.sv
// Key-byte selector: wrapping byte index (compare-and-clear) plus byte mux, MSB byte first.
module rc4_key_sel #(
  parameter int unsigned RAM_WIDTH  = 8,
  parameter int unsigned KEY_LENGTH = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
  input  logic                                 advance,
  input  logic                                 clear,
  output logic [RAM_WIDTH-1:0]                 key_byte_c
);

  localparam int unsigned IW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx <= '0;
    end else if (advance) begin
      idx <= (idx == IW'(KEY_LENGTH - 1)) ? '0 : idx + 1'b1;
    end
  end

  assign key_byte_c = key[IW'(KEY_LENGTH - 1) - idx];

endmodule

// File: rtl/rc4_stream_engine.sv
// RC4 core: S-box init, key schedule, then keystream XOR over a valid/ready byte stream.
// Optional RC4_DROP_EN discards the first DROP_N keystream bytes before streaming.
module rc4_stream_engine
  import rc4_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 8,
  parameter int unsigned KEY_LENGTH = 3,
  parameter int unsigned MSG_LENGTH = 32,
  parameter int unsigned DROP_N     = 256
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
  output logic [RAM_WIDTH-1:0]                 ram_addr,
  output logic [RAM_WIDTH-1:0]                 ram_wdata,
  output logic                                 ram_we,
  input  logic [RAM_WIDTH-1:0]                 ram_rdata,
  input  logic [RAM_WIDTH-1:0]                 s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [RAM_WIDTH-1:0]                 m_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [3:0]                           state_tap
);

  localparam int unsigned CW  = (MSG_LENGTH > 0) ? $clog2(MSG_LENGTH + 1) : 1;
  localparam int unsigned CW1 = CW + 1;
  // DROP_N only takes effect in the RC4_DROP_EN build
`ifdef RC4_DROP_EN
  localparam int unsigned DROP_CNT = DROP_N;
`else
  localparam int unsigned DROP_CNT = DROP_N * 0;
`endif

  state_t                               state, state_nx;
  logic [RAM_WIDTH-1:0]                 i, j, si, sj, byte_q;
  logic [CW-1:0]                        cnt;
  logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key_q;
  logic [RAM_WIDTH-1:0]                 key_byte_c, j_ksa_c, j_prga_c, k_idx_c;
  logic                                 key_adv, key_clr, last_byte_c;

`ifdef RC4_DROP_EN
  localparam int unsigned DW = (DROP_CNT > 0) ? $clog2(DROP_CNT + 1) : 1;
  logic [DW-1:0] drop_cnt;
  logic          dropping;
  logic          drop_last_c;
  assign drop_last_c = (drop_cnt == DW'(DROP_CNT - 1));
`endif

  rc4_key_sel #(.RAM_WIDTH(RAM_WIDTH), .KEY_LENGTH(KEY_LENGTH)) u_key_sel (
    .clk        (clk),
    .reset      (reset),
    .key        (key_q),
    .advance    (key_adv),
    .clear      (key_clr),
    .key_byte_c (key_byte_c)
  );

  assign j_ksa_c     = j + ram_rdata + key_byte_c;
  assign j_prga_c    = j + ram_rdata;
  assign k_idx_c     = si + sj;
  assign last_byte_c = (CW1'(cnt) + CW1'(1)) >= CW1'(MSG_LENGTH);
  assign state_tap   = state;
  // Keystream read address is held through P_OUT, so rdata and m_data stay stable
  assign m_data      = (state == ST_P_OUT) ? (ram_rdata ^ byte_q) : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    key_adv   = 1'b0;
    key_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        key_clr = 1'b1;
        if (start) state_nx = ST_INIT;
      end
      ST_INIT: begin
        ram_addr  = i;
        ram_wdata = i;
        ram_we    = 1'b1;
        if (&i) state_nx = ST_K_RDI;
      end
      ST_K_RDI: begin
        ram_addr = i;
        state_nx = ST_K_RDJ;
      end
      ST_K_RDJ: begin
        ram_addr = j_ksa_c;
        state_nx = ST_K_WRI;
      end
      ST_K_WRI: begin
        ram_addr  = i;
        ram_wdata = ram_rdata;
        ram_we    = 1'b1;
        state_nx  = ST_K_WRJ;
      end
      ST_K_WRJ: begin
        ram_addr  = j;
        ram_wdata = si;
        ram_we    = 1'b1;
        key_adv   = 1'b1;
        if (!(&i))                 state_nx = ST_K_RDI;
        else if (MSG_LENGTH == 0)  state_nx = ST_IDLE;
        else if (DROP_CNT != 0)    state_nx = ST_D_INC;
        else                       state_nx = ST_P_IN;
      end
      ST_P_IN: begin
        ram_addr = i + 1'b1;
        if (s_valid) state_nx = ST_P_RDJ;
      end
      ST_P_RDJ: begin
        ram_addr = j_prga_c;
        state_nx = ST_P_WRI;
      end
      ST_P_WRI: begin
        ram_addr  = i;
        ram_wdata = ram_rdata;
        ram_we    = 1'b1;
        state_nx  = ST_P_WRJ;
      end
      ST_P_WRJ: begin
        ram_addr  = j;
        ram_wdata = si;
        ram_we    = 1'b1;
        state_nx  = ST_P_RDK;
      end
      ST_P_RDK: begin
        ram_addr = k_idx_c;
        state_nx = ST_P_OUT;
`ifdef RC4_DROP_EN
        if (dropping) state_nx = drop_last_c ? ST_P_IN : ST_D_INC;
`endif
      end
      ST_P_OUT: begin
        ram_addr = k_idx_c;
        if (m_ready) state_nx = last_byte_c ? ST_IDLE : ST_P_IN;
      end
`ifdef RC4_DROP_EN
      ST_D_INC: begin
        ram_addr = i + 1'b1;
        state_nx = ST_P_RDJ;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath registers and registered stream/status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      byte_q  <= '0;
      cnt     <= '0;
      key_q   <= '0;
      done    <= 1'b0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
`ifdef RC4_DROP_EN
      drop_cnt <= '0;
      dropping <= 1'b0;
`endif
    end else begin
      s_ready <= (state_nx == ST_P_IN);
      m_valid <= (state_nx == ST_P_OUT);
      busy    <= (state_nx != ST_IDLE);
      case (state)
        ST_IDLE: if (start) begin
          key_q <= key;
          done  <= 1'b0;
          cnt   <= '0;
          i     <= '0;
          j     <= '0;
        end
        ST_INIT: i <= i + 1'b1;
        ST_K_RDJ: begin
          si <= ram_rdata;
          j  <= j_ksa_c;
        end
        ST_K_WRI: sj <= ram_rdata;
        ST_K_WRJ: begin
          i <= i + 1'b1;
          if (&i) begin
            j <= '0;
            if (MSG_LENGTH == 0) done <= 1'b1;
`ifdef RC4_DROP_EN
            dropping <= (DROP_CNT != 0);
            drop_cnt <= '0;
`endif
          end
        end
        ST_P_IN: if (s_valid) begin
          byte_q <= s_data;
          i      <= i + 1'b1;
        end
        ST_P_RDJ: begin
          si <= ram_rdata;
          j  <= j_prga_c;
        end
        ST_P_WRI: sj <= ram_rdata;
        ST_P_OUT: if (m_ready) begin
          cnt <= cnt + 1'b1;
          if (last_byte_c) done <= 1'b1;
        end
`ifdef RC4_DROP_EN
        ST_P_RDK: if (dropping) begin
          drop_cnt <= drop_cnt + 1'b1;
          if (drop_last_c) dropping <= 1'b0;
        end
        ST_D_INC: i <= i + 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_stream_engine.sv
// Scoreboard bench for rc4_stream_engine against a plain-array RC4 reference model.
module tb_rc4_stream_engine;

  localparam int W  = 8;
  localparam int KL = 3;
  localparam int ML = 9;
`ifdef RC4_DROP_EN
  localparam int DROP = 1;
`else
  localparam int DROP = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [KL-1:0][W-1:0] key_a = '0, key_b = '0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [W-1:0] addr_a, wdata_a, rdata_a, m_data_a, addr_b, wdata_b, rdata_b, m_data_b;
  logic [W-1:0] s_data_a = '0;
  logic we_a, s_ready_a, m_valid_a, busy_a, done_a, we_b, s_ready_b, m_valid_b, busy_b, done_b;
  logic s_valid_a = 1'b0, m_ready_a = 1'b0;
  logic [3:0] tap_a, tap_b;
  logic [W-1:0] mem_a [256];
  logic [W-1:0] mem_b [256];
  logic sready_seen_b = 1'b0, mvalid_seen_b = 1'b0;

  rc4_stream_engine #(.RAM_WIDTH(W), .KEY_LENGTH(KL), .MSG_LENGTH(ML), .DROP_N(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .key(key_a),
    .ram_addr(addr_a), .ram_wdata(wdata_a), .ram_we(we_a), .ram_rdata(rdata_a),
    .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .busy(busy_a), .done(done_a), .state_tap(tap_a));

  rc4_stream_engine #(.RAM_WIDTH(W), .KEY_LENGTH(KL), .MSG_LENGTH(0), .DROP_N(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .key(key_b),
    .ram_addr(addr_b), .ram_wdata(wdata_b), .ram_we(we_b), .ram_rdata(rdata_b),
    .s_data(8'h00), .s_valid(1'b1), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(1'b1),
    .busy(busy_b), .done(done_b), .state_tap(tap_b));

  // Behavioural single-port S-box RAMs, one-cycle read latency
  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    rdata_a <= mem_a[addr_a];
    if (we_b) mem_b[addr_b] <= wdata_b;
    rdata_b <= mem_b[addr_b];
  end

  always @(negedge clk) begin
    if (s_ready_b) sready_seen_b <= 1'b1;
    if (m_valid_b) mvalid_seen_b <= 1'b1;
  end

  int total = 0;
  int bad = 0;
  int m_stall_fixed = 0;
  int m_stall_rand = 0;
  logic [7:0] sb_q[$];
  logic [7:0] out_log[$];
  logic [7:0] ks[$];
  logic [7:0] ct[$] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pt[$] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Textbook RC4: KSA, optional drop, then n keystream bytes into ks
  task automatic model_keystream(input logic [23:0] k, input int n);
    int s[256];
    int i, j, t;
    for (int c = 0; c < 256; c++) s[c] = c;
    j = 0;
    for (int c = 0; c < 256; c++) begin
      j = (j + s[c] + int'(8'(k >> (8 * (2 - (c % 3)))))) % 256;
      t = s[c]; s[c] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    ks.delete();
    for (int m = 0; m < n + DROP; m++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (m >= DROP) ks.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    s_data_a = b;
    s_valid_a = 1'b1;
    n = 0;
    do begin
      acc = s_ready_a;
      tick();
      n++;
    end while (!acc && n < 200);
    s_valid_a = 1'b0;
    check("s_accept", 32'(acc), 1);
  endtask

  task automatic run_a(input logic [23:0] k, input logic [7:0] data[$], input int s_gap,
                       input int s_gap_rand, input int hold_start, input bit chk_init);
    int cyc;
    int errs;
    model_keystream(k, data.size());
    out_log.delete();
    key_a = k;
    start_a = 1'b1;
    tick();
    cyc = 0;
    if (hold_start == 0) start_a = 1'b0;
    while (!s_ready_a && cyc < 4000) begin
      tick();
      cyc++;
      if (cyc >= hold_start) start_a = 1'b0;
      if (chk_init && cyc == 256) begin
        errs = 0;
        for (int c = 0; c < 256; c++) if (mem_a[c] !== 8'(c)) errs++;
        check("init_sbox", errs, 0);
      end
    end
    start_a = 1'b0;
`ifndef RC4_DROP_EN
    check("start_to_sready", cyc, 1280);
`else
    check("sready_reached", 32'(s_ready_a), 1);
`endif
    for (int n = 0; n < data.size(); n++) begin
      repeat (s_gap + int'($urandom_range(0, s_gap_rand))) tick();
      sb_q.push_back(data[n] ^ ks[n]);
      send_byte(data[n]);
    end
    cyc = 0;
    while (!(done_a && sb_q.size() == 0) && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("done_after_run", 32'(done_a), 1);
    check("sb_drained", sb_q.size(), 0);
    check("busy_after_run", 32'(busy_a), 0);
  endtask

  // Monitor: applies output backpressure, checks hold-stability, pops the scoreboard
  initial begin
    bit have;
    logic [7:0] held;
    int stall;
    have = 1'b0;
    held = '0;
    stall = 0;
    forever begin
      tick();
      if (m_ready_a) begin
        m_ready_a = 1'b0;
        have = 1'b0;
      end else if (m_valid_a) begin
        if (!have) begin
          have = 1'b1;
          held = m_data_a;
          stall = m_stall_fixed + int'($urandom_range(0, m_stall_rand));
        end else begin
          check("m_data_stable", m_data_a, held);
        end
        if (stall > 0) begin
          stall--;
        end else begin
          out_log.push_back(m_data_a);
          if (sb_q.size() == 0) check("unexpected_output", 32'(m_valid_a), 0);
          else check("m_data", m_data_a, sb_q.pop_front());
          m_ready_a = 1'b1;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] data[$];
    logic [7:0] zeros[$];
    int cyc;
    repeat (3) tick();
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_we", 32'(we_a), 0);
    check("rst_addr", addr_a, 0);
    check("rst_wdata", wdata_a, 0);
    check("rst_s_ready", 32'(s_ready_a), 0);
    check("rst_m_valid", 32'(m_valid_a), 0);
    check("rst_m_data", m_data_a, 0);
    check("rst_state", tap_a, 0);
    reset = 1'b0;
    tick();

    // Zero-length message: key schedule only, no stream activity
    key_b = 24'h4B6579;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 3000) begin tick(); cyc++; end
    check("len0_done", 32'(done_b), 1);
    check("len0_busy", 32'(busy_b), 0);
    check("len0_no_s_ready", 32'(sready_seen_b), 0);
    check("len0_no_m_valid", 32'(mvalid_seen_b), 0);

    // Known-answer decrypt of "Plaintext" under key "Key"
    run_a(24'h4B6579, ct, 0, 0, 0, 1'b1);
`ifndef RC4_DROP_EN
    for (int n = 0; n < ML; n++) check("kat_plain", out_log[n], pt[n]);
`endif

    // Same message with input and output backpressure
    m_stall_fixed = 7;
    run_a(24'h4B6579, ct, 5, 0, 0, 1'b0);
`ifndef RC4_DROP_EN
    for (int n = 0; n < ML; n++) check("bp_plain", out_log[n], pt[n]);
`endif
    m_stall_fixed = 0;

    // Random keys and data with random stalls; first run holds start high while busy
    m_stall_rand = 3;
    for (int r = 0; r < 3; r++) begin
      data.delete();
      for (int n = 0; n < ML; n++) data.push_back(8'($urandom));
      run_a(24'($urandom), data, 0, 3, (r == 0) ? 700 : 0, 1'b0);
    end
    m_stall_rand = 0;

    // Abort during key schedule, then restart with the same key
    key_a = 24'h4B6579;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (600) tick();
    check("mid_ksa_busy", 32'(busy_a), 1);
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(busy_a), 0);
    check("abort_done", 32'(done_a), 0);
    check("abort_we", 32'(we_a), 0);
    reset = 1'b0;
    tick();
    for (int n = 0; n < ML; n++) zeros.push_back(8'h00);
    run_a(24'h4B6579, zeros, 0, 0, 0, 1'b0);
`ifdef RC4_DROP_EN
    check("restart_first_ks", out_log[0], 8'h9F);
`else
    check("restart_first_ks", out_log[0], 8'hEB);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc4_stream_engine.md
Name: rc4_stream_engine

Overview:
- Parametrised RC4 core. Runs the full key schedule (S-box init and key-driven shuffle) and then the keystream phase, XORing an input byte stream into an output byte stream.
- Successor to the fixed 3-byte init/shuffle sequencer. Adds keystream generation, valid/ready streaming, message-length termination, parametric key length and S-box width.
- Drives an external single-port S-box RAM.
- Sits between the cracking/key-search control and the encrypted-message ROM / decrypted-message RAM.

Parameters:
- RAM_WIDTH, 8: data and address width; S-box depth is 2^RAM_WIDTH.
- KEY_LENGTH, 3: key bytes; must be ≥1.
- MSG_LENGTH, 32: bytes processed per run; 0 is legal.
- DROP_N, 256: discarded keystream bytes; used only with RC4_DROP_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin run; sampled in IDLE only
- key  in  [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  key; byte k = key[KEY_LENGTH-1-k], so the MSB byte is used first
- ram_addr  out  RAM_WIDTH  S-box address
- ram_wdata  out  RAM_WIDTH  S-box write data
- ram_we  out  1  S-box write enable
- ram_rdata  in  RAM_WIDTH  S-box read data; valid the cycle after the address is presented
- s_data  in  RAM_WIDTH  input (cipher/plain) byte
- s_valid  in  1  input valid
- s_ready  out  1  input accepted when s_valid&s_ready
- m_data  out  RAM_WIDTH  s_data XOR keystream
- m_valid  out  1  output valid
- m_ready  in  1  output accepted when m_valid&m_ready
- busy  out  1  high in every state except IDLE
- done  out  1  level; set on run completion, cleared on next accepted start
- state_tap  out  4  current state encoding, for debug

Behaviour:
- Reset state: state=IDLE; i=j=0.
- Outputs at reset: ram_addr=0, ram_wdata=0, ram_we=0, s_ready=0, m_data=0, m_valid=0, busy=0, done=0.
- Reset mid-run aborts immediately. There is no S-box cleanup.
- IDLE:
  - start=1 → INIT, done←0, key latched.
  - start while busy is ignored.
- INIT: one write per cycle, S[c]=c for c=0..2^W-1; exactly 2^W cycles. Then KSA with i=j=0.
- KSA: 4 cycles per i, 4·2^W cycles total. Sum in each iteration is j+S[i]+keybyte(i mod KEY_LENGTH).
  - K_RDI: addr=i.
  - K_RDJ: si←rdata; j←sum (mod 2^W); addr=new j.
  - K_WRI: sj←rdata; write S[i]=sj.
  - K_WRJ: write S[j]=si; i++.
  - After i wraps to 0: i=j=0, then P_IN (or DROP with the macro).
  - If MSG_LENGTH=0: go to IDLE, done←1.
- PRGA: per byte, minimum 6 cycles.
  - P_IN: s_ready=1; on handshake latch s_data, i←i+1, addr=i+1.
  - P_RDJ: si←rdata; j←j+si; addr=new j.
  - P_WRI: sj←rdata; write S[i]=sj.
  - P_WRJ: write S[j]=si.
  - P_RDK: addr=si+sj (mod 2^W).
  - P_OUT: m_data=rdata^latched byte, held stable; m_valid=1 until m_ready.
  - After handshake: byte count ≥ MSG_LENGTH → IDLE, done←1; else P_IN.
- Stream rules:
  - s_ready is high only in P_IN.
  - m_valid never depends combinationally on m_ready.
  - No s_ready in the same cycle as m_valid.
- Arithmetic: all index arithmetic is modulo 2^RAM_WIDTH by natural wrap. The byte counter is sized ceil(log2(MSG_LENGTH+1)).
- Key index: wraps at KEY_LENGTH. A non-power-of-two length uses a compare-and-clear counter, not a modulo.
- Same-index swap (i==j): write order I then J leaves S unchanged; this is required.

Optional Feature:
- Macro RC4_DROP_EN.
- When defined: after KSA, run DROP_N PRGA iterations (states P_RDJ..P_RDK) without handshakes. s_ready=0 and m_valid=0 during the drop. Then P_IN.
- When undefined: DROP_N is unused; KSA goes directly to P_IN.

Decomposition:
- Package rc4_pkg: state_t enum, 4-bit encodings fixed for state_tap; RAM_RD_LATENCY=1 constant.
- Sub-module rc4_key_sel: key-byte index counter with wrap plus byte mux. Inputs: advance and clear. Output: key byte.
- The FSM and datapath stay in rc4_stream_engine.

Test Plan:
- Key 0x4B6579 ("Key"), MSG_LENGTH=9, feed BB F3 16 E8 D9 40 AF 0A D3 → m_data = 50 6C 61 69 6E 74 65 78 74 ("Plaintext"); done=1 after the last handshake.
- Cycle count: start → first s_ready=1 exactly 256+1024 cycles later (W=8, macro off). Scoreboard S after INIT matches S[c]=c.
- Backpressure: hold s_valid=0 for 5 cycles and m_ready=0 for 7 cycles per byte → identical output bytes; m_data stable while stalled.
- reset=1 asserted during KSA at cycle 600 → next cycle busy=0, done=0, ram_we=0. A restart with the same key produces the identical first keystream byte EB.
- MSG_LENGTH=0 → done=1, and s_ready never asserts. Start held high while busy → no restart.
- RC4_DROP_EN, DROP_N=1, key "Key", input 00 → output 9F (the second keystream byte).
